mux_pipeline_stream: RTL

- Pipelined N-ary tree multiplexer with a valid/ready stream handshake, for high-speed datapaths.
- Selects one of INPUT_COUNT lanes of WIDTH bits using a tree of MUX_SIZE-input stages, with one register level per tree level.
- The select value travels down the pipeline with its data, so every sample's selection is coherent and a new select can be issued every cycle.
- Supports backpressure, reset, and out-of-range select detection; sits between parallel producers and a single stream consumer.

---
 rtl/mux_pipeline_stream_pkg.sv | 51 +++++
 rtl/mux_pipeline_stream_stage.sv | 101 ++++++++++
 rtl/mux_pipeline_stream.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/mux_pipeline_stream_pkg.sv
// mux_pipeline_stream_pkg
//   Shared elaboration-time helpers for the pipelined tree multiplexer:
//   tree depth, select-digit width, per-level lane counts and lane offsets.
//   Pure constant functions; no ports, no state.
package mux_pipeline_stream_pkg;

    // Bits of select consumed by one tree level (radix is a power of 2).
    function automatic int unsigned f_digit_width(input int unsigned radix);
        return $clog2(radix);
    endfunction

    function automatic int unsigned f_ceil_div(input int unsigned a, input int unsigned b);
        return (a + b - 1) / b;
    endfunction

    // Number of inputs seen by tree level 'level' (level 0 sees the lanes).
    function automatic int unsigned f_count_at_level(input int unsigned count,
                                                     input int unsigned radix,
                                                     input int unsigned level);
        int unsigned c;
        c = count;
        for (int unsigned i = 0; i < level; i++) begin
            c = f_ceil_div(c, radix);
        end
        return c;
    endfunction

    // ceil(log_radix(count)), never less than one register level.
    function automatic int unsigned f_levels(input int unsigned count,
                                             input int unsigned radix);
        int unsigned c;
        int unsigned l;
        c = count;
        l = 0;
        while (c > 1) begin
            c = f_ceil_div(c, radix);
            l++;
        end
        if (l == 0) begin
            l = 1;
        end
        return l;
    endfunction

    // LSB position of lane 'lane' in a flattened lane bus.
    function automatic int unsigned f_lane_lsb(input int unsigned lane,
                                               input int unsigned width);
        return lane * width;
    endfunction

endpackage

// File: rtl/mux_pipeline_stream_stage.sv
// mux_pipeline_stream_stage
//   One registered level of the tree multiplexer. Groups the upstream
//   items in consecutive blocks of MUX_SIZE and picks one per block using
//   select digit sel[LEVEL*D +: D]; the sample's valid, full sel and err
//   travel with the data.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   up_valid/up_data/up_sel/up_err   upstream sample
//   up_ready                   this stage loads this cycle
//   dn_valid/dn_data/dn_sel/dn_err   registered sample to the next level
//   dn_ready                   next level (or consumer) loads this cycle
module mux_pipeline_stream_stage
    import mux_pipeline_stream_pkg::*;
#(
    parameter int unsigned WIDTH                = 4,
    parameter int unsigned INPUT_COUNT_AT_LEVEL = 10,
    parameter int unsigned MUX_SIZE             = 2,
    parameter int unsigned LEVEL                = 0,
    parameter int unsigned SEL_W                = 4
) (
    input  logic                                                      clk,
    input  logic                                                      rst_n,
    input  logic                                                      up_valid,
    input  logic [WIDTH*INPUT_COUNT_AT_LEVEL-1:0]                     up_data,
    input  logic [SEL_W-1:0]                                          up_sel,
    input  logic                                                      up_err,
    output logic                                                      up_ready,
    output logic                                                      dn_valid,
    output logic [WIDTH*f_ceil_div(INPUT_COUNT_AT_LEVEL, MUX_SIZE)-1:0] dn_data,
    output logic [SEL_W-1:0]                                          dn_sel,
    output logic                                                      dn_err,
    input  logic                                                      dn_ready
);

    localparam int unsigned OUT_COUNT = f_ceil_div(INPUT_COUNT_AT_LEVEL, MUX_SIZE);
    localparam int unsigned DIGIT_W   = f_digit_width(MUX_SIZE);
    localparam int unsigned PAD_W     = WIDTH * MUX_SIZE * OUT_COUNT;

    logic [PAD_W-1:0]           padded;
    logic [DIGIT_W-1:0]         digit;
    logic [WIDTH*OUT_COUNT-1:0] mux_data;
    logic                       load;

    logic                       valid_q, valid_d;
    logic [WIDTH*OUT_COUNT-1:0] data_q,  data_d;
    logic [SEL_W-1:0]           sel_q,   sel_d;
    logic                       err_q,   err_d;

    // Zero-padding the last partial block makes an out-of-range digit
    // pick zero data without any per-input guard.
    assign padded = PAD_W'(up_data);

    // Digits above SEL_W read as zero because the shift fills with zeros.
    assign digit = DIGIT_W'(up_sel >> (LEVEL * DIGIT_W));

    always_comb begin
        mux_data = '0;
        for (int unsigned g = 0; g < OUT_COUNT; g++) begin
            mux_data[f_lane_lsb(g, WIDTH) +: WIDTH] =
                padded[f_lane_lsb(g * MUX_SIZE + 32'(digit), WIDTH) +: WIDTH];
        end
    end

    assign load = !valid_q || dn_ready;

    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        sel_d   = sel_q;
        err_d   = err_q;
        if (load) begin
            valid_d = up_valid;
            if (up_valid) begin
                data_d = up_err ? '0 : mux_data;
                sel_d  = up_sel;
                err_d  = up_err;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            sel_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            err_q   <= err_d;
        end
    end

    assign up_ready = load;
    assign dn_valid = valid_q;
    assign dn_data  = data_q;
    assign dn_sel   = sel_q;
    assign dn_err   = err_q;

endmodule

// File: rtl/mux_pipeline_stream.sv
// mux_pipeline_stream
//   Pipelined MUX_SIZE-ary tree multiplexer with a valid/ready stream
//   handshake. One register level per tree level; the select travels with
//   its data, so a new select may be issued every cycle. Selects at or
//   above INPUT_COUNT flag out_err and produce zero data.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid, in_ready    input handshake
//   sel                   lane select, sampled with in_valid
//   in                    lanes, lane i at [i*WIDTH +: WIDTH]
//   out_valid, out_ready  output handshake
//   out, out_sel, out_err selected data, its select, out-of-range flag
// Build option:
//   MUX_PIPELINE_STREAM_SKID_EN  adds a 2-entry input skid buffer so that
//   in_ready is a flop output (latency LEVELS+1). Undefined: in_ready is
//   the combinational ready chain (latency LEVELS).
module mux_pipeline_stream
    import mux_pipeline_stream_pkg::*;
#(
    parameter  int unsigned WIDTH       = 4,
    parameter  int unsigned INPUT_COUNT = 10,
    parameter  int unsigned MUX_SIZE    = 2,
    localparam int unsigned SEL_W       = $clog2(INPUT_COUNT),
    localparam int unsigned LEVELS      = f_levels(INPUT_COUNT, MUX_SIZE)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SEL_W-1:0]             sel,
    input  logic [WIDTH*INPUT_COUNT-1:0] in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out,
    output logic [SEL_W-1:0]             out_sel,
    output logic                         out_err
);

    localparam int unsigned BUS_W = WIDTH * INPUT_COUNT;

    logic             src_valid;
    logic [BUS_W-1:0] src_data;
    logic [SEL_W-1:0] src_sel;
    logic             src_err;
    logic             src_ready;

`ifdef MUX_PIPELINE_STREAM_SKID_EN
    logic             buf_valid_q,  buf_valid_d;
    logic [BUS_W-1:0] buf_data_q,   buf_data_d;
    logic [SEL_W-1:0] buf_sel_q,    buf_sel_d;
    logic             skid_valid_q, skid_valid_d;
    logic [BUS_W-1:0] skid_data_q,  skid_data_d;
    logic [SEL_W-1:0] skid_sel_q,   skid_sel_d;
    logic             in_ready_q,   in_ready_d;
    logic             push;
    logic             pop;

    assign push = in_valid && in_ready_q;
    assign pop  = buf_valid_q && src_ready;

    // buf feeds the tree; skid only catches the sample accepted in the
    // cycle that downstream stalled, which is what lets in_ready be a flop.
    always_comb begin
        buf_valid_d  = buf_valid_q;
        buf_data_d   = buf_data_q;
        buf_sel_d    = buf_sel_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        skid_sel_d   = skid_sel_q;
        if (skid_valid_q) begin
            if (pop) begin
                buf_data_d   = skid_data_q;
                buf_sel_d    = skid_sel_q;
                skid_valid_d = 1'b0;
            end
        end else begin
            if (pop) begin
                buf_valid_d = 1'b0;
            end
            if (push) begin
                if (!buf_valid_q || pop) begin
                    buf_valid_d = 1'b1;
                    buf_data_d  = in;
                    buf_sel_d   = sel;
                end else begin
                    skid_valid_d = 1'b1;
                    skid_data_d  = in;
                    skid_sel_d   = sel;
                end
            end
        end
        in_ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_valid_q  <= 1'b0;
            buf_data_q   <= '0;
            buf_sel_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_data_q  <= '0;
            skid_sel_q   <= '0;
            in_ready_q   <= 1'b1;
        end else begin
            buf_valid_q  <= buf_valid_d;
            buf_data_q   <= buf_data_d;
            buf_sel_q    <= buf_sel_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
            skid_sel_q   <= skid_sel_d;
            in_ready_q   <= in_ready_d;
        end
    end

    assign src_valid = buf_valid_q;
    assign src_data  = buf_data_q;
    assign src_sel   = buf_sel_q;
    assign in_ready  = in_ready_q;
`else
    assign src_valid = in_valid;
    assign src_data  = in;
    assign src_sel   = sel;
    assign in_ready  = src_ready;
`endif

    assign src_err = (32'(src_sel) >= INPUT_COUNT);

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int unsigned CNT_IN  = f_count_at_level(INPUT_COUNT, MUX_SIZE, k);
        localparam int unsigned CNT_OUT = f_ceil_div(CNT_IN, MUX_SIZE);

        logic                      up_valid;
        logic [WIDTH*CNT_IN-1:0]   up_data;
        logic [SEL_W-1:0]          up_sel;
        logic                      up_err;
        logic                      up_ready;
        logic                      dn_valid;
        logic [WIDTH*CNT_OUT-1:0]  dn_data;
        logic [SEL_W-1:0]          dn_sel;
        logic                      dn_err;
        logic                      dn_ready;

        if (k == 0) begin : g_head
            assign up_valid  = src_valid;
            assign up_data   = src_data;
            assign up_sel    = src_sel;
            assign up_err    = src_err;
            assign src_ready = up_ready;
        end else begin : g_body
            assign up_valid = g_lvl[k-1].dn_valid;
            assign up_data  = g_lvl[k-1].dn_data;
            assign up_sel   = g_lvl[k-1].dn_sel;
            assign up_err   = g_lvl[k-1].dn_err;
        end

        if (k == LEVELS - 1) begin : g_tail
            assign dn_ready  = out_ready;
            assign out_valid = dn_valid;
            assign out       = dn_data;
            assign out_sel   = dn_sel;
            assign out_err   = dn_err;
        end else begin : g_link
            assign dn_ready = g_lvl[k+1].up_ready;
        end

        mux_pipeline_stream_stage #(
            .WIDTH               (WIDTH),
            .INPUT_COUNT_AT_LEVEL(CNT_IN),
            .MUX_SIZE            (MUX_SIZE),
            .LEVEL               (k),
            .SEL_W               (SEL_W)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .up_valid(up_valid),
            .up_data (up_data),
            .up_sel  (up_sel),
            .up_err  (up_err),
            .up_ready(up_ready),
            .dn_valid(dn_valid),
            .dn_data (dn_data),
            .dn_sel  (dn_sel),
            .dn_err  (dn_err),
            .dn_ready(dn_ready)
        );
    end

endmodule
